// File: rtl/pulse_data_sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pulse_data_sync_pkg                                    |
// | Description : Shared CDC constants and parameter legality helper.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package pulse_data_sync_pkg;

  // Enable encodings understood by the data synchronizer
  localparam int EN_LEVEL  = 0;
  localparam int EN_TOGGLE = 1;

  // Fewer flops than this do not give a useful MTBF
  localparam int SYNC_MIN_STAGES = 2;

  // True when a synchronizer configuration is legal
  function automatic bit sync_params_ok(int n_stages, int bus_width, int en_mode);
    return (n_stages >= SYNC_MIN_STAGES) && (bus_width >= 1) &&
           ((en_mode == EN_LEVEL) || (en_mode == EN_TOGGLE));
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_data_sync_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pulse_data_sync_if                                     |
// | Description : Source bus/enable and destination capture signals.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface pulse_data_sync_if #(
  parameter int BUS_WIDTH = 8
);

  logic [BUS_WIDTH-1:0] UNSYNC_BUS;
  logic                 BUS_EN;
  logic [BUS_WIDTH-1:0] SYNC_BUS;
  logic                 ENABLE_PULSE;
  logic                 ACK_TGL;

  // Source side: presents data and enable, watches the acknowledge
  modport master (
    output UNSYNC_BUS,
    output BUS_EN,
    input  SYNC_BUS,
    input  ENABLE_PULSE,
    input  ACK_TGL
  );

  // Synchronizer side: samples data and enable, returns capture results
  modport slave (
    input  UNSYNC_BUS,
    input  BUS_EN,
    output SYNC_BUS,
    output ENABLE_PULSE,
    output ACK_TGL
  );

endinterface
`default_nettype wire

// File: rtl/pulse_data_sync_en_sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : en_sync_chain                                          |
// | Description : Single-bit N-stage flop synchronizer, async clear.     |
// |               Also usable on the source side for ACK_TGL.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module en_sync_chain
  import pulse_data_sync_pkg::*;
#(
  parameter int N_STAGES = 2
) (
  input  wire logic D_CLK,
  input  wire logic D_RST,
  input  wire logic d,
  output wire logic q
);

  logic [N_STAGES-1:0] r_sync;

  // Reject chains too short to resolve metastability
  generate
    if (N_STAGES < SYNC_MIN_STAGES) begin : g_bad_depth
      $error("en_sync_chain: N_STAGES must be >= SYNC_MIN_STAGES");
    end
  endgenerate

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge D_CLK or negedge D_RST) begin
    if (!D_RST) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_STAGES-2:0], d};
    end
  end

  assign q = r_sync[N_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pulse_data_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : pulse_data_sync                                        |
// | Description : Multi-bit CDC: enable is synchronized, its edge        |
// |               captures the quasi-static source bus, emits a strobe   |
// |               and flips an acknowledge toggle for flow control.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module pulse_data_sync
  import pulse_data_sync_pkg::*;
#(
  parameter int N_STAGES  = 2,
  parameter int BUS_WIDTH = 8,
  parameter int EN_MODE   = EN_LEVEL
) (
  input  wire logic        D_CLK,
  input  wire logic        D_RST,
  pulse_data_sync_if.slave bus
);

  logic                 w_s_en;
  logic                 w_event;
  logic                 r_s_prev;
  logic [BUS_WIDTH-1:0] r_sync_bus;
  logic                 r_enable_pulse;
  logic                 r_ack_tgl;

  // Configuration legality, including agreement with the interface width
  generate
    if (!sync_params_ok(N_STAGES, BUS_WIDTH, EN_MODE) ||
        ($bits(bus.SYNC_BUS) != BUS_WIDTH)) begin : g_bad_params
      $error("pulse_data_sync: illegal N_STAGES/BUS_WIDTH/EN_MODE");
    end
  endgenerate

  // Only the enable crosses through flops; the bus is held by the source
  en_sync_chain #(
    .N_STAGES (N_STAGES)
  ) u_en_sync (
    .D_CLK (D_CLK),
    .D_RST (D_RST),
    .d     (bus.BUS_EN),
    .q     (w_s_en)
  );

  // Remember last synchronized enable for edge detection
  always_ff @(posedge D_CLK or negedge D_RST) begin
    if (!D_RST) begin
      r_s_prev <= 1'b0;
    end else begin
      r_s_prev <= w_s_en;
    end
  end

  // Event source fixed at elaboration: rising edge or any change
  generate
    if (EN_MODE == EN_TOGGLE) begin : g_toggle
      assign w_event = w_s_en ^ r_s_prev;
    end else begin : g_level
      assign w_event = w_s_en & ~r_s_prev;
    end
  endgenerate

  // Capture bus, strobe and flip ack on each event; hold bus otherwise
  always_ff @(posedge D_CLK or negedge D_RST) begin
    if (!D_RST) begin
      r_sync_bus     <= '0;
      r_enable_pulse <= 1'b0;
      r_ack_tgl      <= 1'b0;
    end else begin
      r_enable_pulse <= w_event;
      if (w_event) begin
        r_sync_bus <= bus.UNSYNC_BUS;
        r_ack_tgl  <= ~r_ack_tgl;
      end
    end
  end

  assign bus.SYNC_BUS     = r_sync_bus;
  assign bus.ENABLE_PULSE = r_enable_pulse;
  assign bus.ACK_TGL      = r_ack_tgl;

endmodule
`default_nettype wire

// File: tb/tb_pulse_data_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_pulse_data_sync                                     |
// | Description : Directed self-checking bench for three configurations: |
// |               level N=2 W=8, toggle N=2 W=8, level N=4 W=1.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_pulse_data_sync;
  import pulse_data_sync_pkg::*;

  logic D_CLK = 1'b0;
  logic D_RST = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   pulses;

  pulse_data_sync_if #(.BUS_WIDTH(8)) a_if ();
  pulse_data_sync_if #(.BUS_WIDTH(8)) b_if ();
  pulse_data_sync_if #(.BUS_WIDTH(1)) c_if ();

  pulse_data_sync #(.N_STAGES(2), .BUS_WIDTH(8), .EN_MODE(EN_LEVEL)) u_a (
    .D_CLK (D_CLK), .D_RST (D_RST), .bus (a_if.slave));
  pulse_data_sync #(.N_STAGES(2), .BUS_WIDTH(8), .EN_MODE(EN_TOGGLE)) u_b (
    .D_CLK (D_CLK), .D_RST (D_RST), .bus (b_if.slave));
  pulse_data_sync #(.N_STAGES(4), .BUS_WIDTH(1), .EN_MODE(EN_LEVEL)) u_c (
    .D_CLK (D_CLK), .D_RST (D_RST), .bus (c_if.slave));

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  always #5 D_CLK = ~D_CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic step();
    @(posedge D_CLK);
    #1;
  endtask

  initial begin
    a_if.UNSYNC_BUS = 8'h00; a_if.BUS_EN = 1'b0;
    b_if.UNSYNC_BUS = 8'h00; b_if.BUS_EN = 1'b0;
    c_if.UNSYNC_BUS = 1'b0;  c_if.BUS_EN = 1'b0;

    // Asynchronous reset before any clock edge
    #2;
    a_if.UNSYNC_BUS = 8'hFF; a_if.BUS_EN = 1'b1;
    b_if.BUS_EN = 1'b1; c_if.BUS_EN = 1'b1;
    D_RST = 1'b0;
    #1;
    check("rst_bus",   a_if.SYNC_BUS,          8'h00);
    check("rst_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    check("rst_ack",   {7'b0, a_if.ACK_TGL},      8'h00);
    check("rst_c_bus", {7'b0, c_if.SYNC_BUS},     8'h00);

    step(); step();
    a_if.BUS_EN = 1'b0; b_if.BUS_EN = 1'b0; c_if.BUS_EN = 1'b0;
    D_RST = 1'b1;
    repeat (5) step();

    // Level mode: one pulse two edges after k0, then nothing while held
    a_if.UNSYNC_BUS = 8'hA5; a_if.BUS_EN = 1'b1;
    step();  check("lvl_k0_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    step();  check("lvl_k1_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
             check("lvl_k1_bus",   a_if.SYNC_BUS,             8'h00);
    step();  check("lvl_k2_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h01);
             check("lvl_k2_bus",   a_if.SYNC_BUS,             8'hA5);
             check("lvl_k2_ack",   {7'b0, a_if.ACK_TGL},      8'h01);
    step();  check("lvl_k3_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    pulses = 0;
    repeat (7) begin
      step();
      if (a_if.ENABLE_PULSE) pulses++;
    end
    check("lvl_no_more_pulses", pulses[7:0], 8'h00);
    check("lvl_ack_held", {7'b0, a_if.ACK_TGL}, 8'h01);

    // Bus change with no event is ignored
    a_if.UNSYNC_BUS = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      step();
      check("ign_bus",   a_if.SYNC_BUS,             8'hA5);
      check("ign_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    end

    // Toggle mode: rise carries 8'h11, fall carries 8'h22
    b_if.UNSYNC_BUS = 8'h11; b_if.BUS_EN = 1'b1;
    step();  check("tgl1_k0_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);
    step();  check("tgl1_k1_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);
    step();  check("tgl1_k2_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h01);
             check("tgl1_k2_bus",   b_if.SYNC_BUS,             8'h11);
             check("tgl1_k2_ack",   {7'b0, b_if.ACK_TGL},      8'h01);
    step();  check("tgl1_k3_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);
    b_if.UNSYNC_BUS = 8'h22; b_if.BUS_EN = 1'b0;
    step();  check("tgl2_k0_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);
    step();  check("tgl2_k1_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);
             check("tgl2_k1_bus",   b_if.SYNC_BUS,             8'h11);
    step();  check("tgl2_k2_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h01);
             check("tgl2_k2_bus",   b_if.SYNC_BUS,             8'h22);
             check("tgl2_k2_ack",   {7'b0, b_if.ACK_TGL},      8'h00);
    step();  check("tgl2_k3_pulse", {7'b0, b_if.ENABLE_PULSE}, 8'h00);

    // Depth 4: pulse exactly after edge k0+4
    c_if.UNSYNC_BUS = 1'b1; c_if.BUS_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dep_early_pulse", {7'b0, c_if.ENABLE_PULSE}, 8'h00);
    end
    step();  check("dep_k4_pulse", {7'b0, c_if.ENABLE_PULSE}, 8'h01);
             check("dep_k4_bus",   {7'b0, c_if.SYNC_BUS},     8'h01);
    step();  check("dep_k5_pulse", {7'b0, c_if.ENABLE_PULSE}, 8'h00);

    // Reset mid-operation: in-flight event lost, fresh event after release
    a_if.BUS_EN = 1'b0;
    repeat (4) step();
    a_if.UNSYNC_BUS = 8'h5A; a_if.BUS_EN = 1'b1;
    step();  check("mid_k0_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    step();  check("mid_k1_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    D_RST = 1'b0;
    #1;
    check("mid_rst_bus",   a_if.SYNC_BUS,             8'h00);
    check("mid_rst_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    check("mid_rst_ack",   {7'b0, a_if.ACK_TGL},      8'h00);
    step();  check("mid_rst_hold_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    step();  check("mid_rst_hold_bus",   a_if.SYNC_BUS,             8'h00);
    D_RST = 1'b1;
    step();  check("mid_r0_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
    step();  check("mid_r1_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);
             check("mid_r1_bus",   a_if.SYNC_BUS,             8'h00);
    step();  check("mid_r2_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h01);
             check("mid_r2_bus",   a_if.SYNC_BUS,             8'h5A);
             check("mid_r2_ack",   {7'b0, a_if.ACK_TGL},      8'h01);
    step();  check("mid_r3_pulse", {7'b0, a_if.ENABLE_PULSE}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
